// File: rtl/inst_pkg.sv
// Shared definitions for the instruction decode stage.
//   fmt_e       : 3-bit instruction format code (NONE, R, I, S, B, U, J)
//   OPC_*       : base opcodes recognised by the decoder
//   *_LSB/*_W   : bit positions and widths of the fixed instruction fields
//   dec_t       : width-independent decoded fields carried through the buffer
//   opcode_fmt  : opcode -> format lookup
package inst_pkg;

   typedef enum logic [2:0] {
      FMT_NONE = 3'd0,
      FMT_R    = 3'd1,
      FMT_I    = 3'd2,
      FMT_S    = 3'd3,
      FMT_B    = 3'd4,
      FMT_U    = 3'd5,
      FMT_J    = 3'd6
   } fmt_e;

   localparam logic [6:0] OPC_OP        = 7'b0110011;
   localparam logic [6:0] OPC_OP_32     = 7'b0111011;
   localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OPC_LOAD      = 7'b0000011;
   localparam logic [6:0] OPC_JALR      = 7'b1100111;
   localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
   localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
   localparam logic [6:0] OPC_STORE     = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
   localparam logic [6:0] OPC_LUI       = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
   localparam logic [6:0] OPC_JAL       = 7'b1101111;

   localparam int unsigned OPC_LSB = 0;
   localparam int unsigned OPC_W   = 7;
   localparam int unsigned RD_LSB  = 7;
   localparam int unsigned F3_LSB  = 12;
   localparam int unsigned F3_W    = 3;
   localparam int unsigned RS1_LSB = 15;
   localparam int unsigned RS2_LSB = 20;
   localparam int unsigned F7_LSB  = 25;
   localparam int unsigned F7_W    = 7;
   localparam int unsigned REG_W   = 5;

   typedef struct packed {
      logic [6:0] opcode;
      logic [2:0] funct3;
      logic [6:0] funct7;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      fmt_e       fmt;
      logic       illegal;
   } dec_t;

   function automatic fmt_e opcode_fmt(input logic [6:0] opc);
      fmt_e f;
      case (opc)
         OPC_OP, OPC_OP_32:                         f = FMT_R;
         OPC_OP_IMM, OPC_OP_IMM_32, OPC_LOAD,
         OPC_JALR, OPC_SYSTEM, OPC_MISC_MEM:        f = FMT_I;
         OPC_STORE:                                 f = FMT_S;
         OPC_BRANCH:                                f = FMT_B;
         OPC_LUI, OPC_AUIPC:                        f = FMT_U;
         OPC_JAL:                                   f = FMT_J;
         default:                                   f = FMT_NONE;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/inst_imm_gen.sv
// Combinational immediate generator.
//   inst_i : raw 32-bit instruction word
//   fmt_i  : format code (inst_pkg::fmt_e values)
//   imm_o  : immediate sign-extended from inst[31] to XLEN; zero for R/NONE
module inst_imm_gen
   import inst_pkg::*;
#(
   parameter int unsigned XLEN = 64
) (
   input  logic [31:0]     inst_i,
   input  logic [2:0]      fmt_i,
   output logic [XLEN-1:0] imm_o
);

   logic [31:0] imm32;
   logic        unused_opc_bits;

   // Opcode bits only steer fmt_i upstream; they never land in an immediate.
   assign unused_opc_bits = ^inst_i[6:0];

   always_comb begin
      imm32 = '0;
      case (fmt_i)
         FMT_I:   imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
         FMT_S:   imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
         FMT_B:   imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7],
                           inst_i[30:25], inst_i[11:8], 1'b0};
         FMT_U:   imm32 = {inst_i[31:12], 12'b0};
         FMT_J:   imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12],
                           inst_i[20], inst_i[30:21], 1'b0};
         default: imm32 = '0;
      endcase
   end

   // Every 32-bit form already carries inst[31] in its top bit, so a signed
   // widening cast gives the XLEN result for both 32 and 64.
   assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/inst_decode_stage.sv
// Instruction decode stage with a 2-entry (head + skid) output buffer.
//   clk, rst              : clock, asynchronous active-high reset
//   in_valid/in_ready     : upstream handshake; in_ready is registered
//   in_inst, in_pc        : instruction word and its PC
//   flush                 : drop every buffered entry at the next edge
//   out_valid/out_ready   : downstream handshake on the head entry
//   out_pc .. out_illegal : decoded fields of the head entry
module inst_decode_stage
   import inst_pkg::*;
#(
   parameter int unsigned XLEN = 64,
   parameter int unsigned PC_W = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_inst,
   input  logic [PC_W-1:0] in_pc,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [PC_W-1:0] out_pc,
   output logic [6:0]      out_opcode,
   output logic [2:0]      out_funct3,
   output logic [6:0]      out_funct7,
   output logic [4:0]      out_rs1,
   output logic [4:0]      out_rs2,
   output logic [4:0]      out_rd,
   output logic [XLEN-1:0] out_imm,
   output logic [2:0]      out_fmt,
   output logic            out_illegal
);

   dec_t            dec;
   logic [XLEN-1:0] dec_imm;

   logic            head_valid_q, head_valid_d;
   dec_t            head_f_q,     head_f_d;
   logic [PC_W-1:0] head_pc_q,    head_pc_d;
   logic [XLEN-1:0] head_imm_q,   head_imm_d;

   logic            skid_valid_q, skid_valid_d;
   dec_t            skid_f_q,     skid_f_d;
   logic [PC_W-1:0] skid_pc_q,    skid_pc_d;
   logic [XLEN-1:0] skid_imm_q,   skid_imm_d;

   logic            in_ready_q,   in_ready_d;
   logic            in_xfer, out_xfer;

   // Input-side decode
   always_comb begin
      dec         = '0;
      dec.opcode  = in_inst[OPC_LSB +: OPC_W];
      dec.rd      = in_inst[RD_LSB  +: REG_W];
      dec.funct3  = in_inst[F3_LSB  +: F3_W];
      dec.rs1     = in_inst[RS1_LSB +: REG_W];
      dec.rs2     = in_inst[RS2_LSB +: REG_W];
      dec.funct7  = in_inst[F7_LSB  +: F7_W];
      dec.fmt     = opcode_fmt(dec.opcode);
      // Compressed encodings are not supported.
      if (in_inst[1:0] != 2'b11) begin
         dec.fmt = FMT_NONE;
      end
      dec.illegal = (dec.fmt == FMT_NONE);
   end

   inst_imm_gen #(
      .XLEN (XLEN)
   ) u_imm_gen (
      .inst_i (in_inst),
      .fmt_i  (dec.fmt),
      .imm_o  (dec_imm)
   );

   assign in_xfer  = in_valid && in_ready_q;
   assign out_xfer = head_valid_q && out_ready;

   always_comb begin
      head_valid_d = head_valid_q;
      head_f_d     = head_f_q;
      head_pc_d    = head_pc_q;
      head_imm_d   = head_imm_q;
      skid_valid_d = skid_valid_q;
      skid_f_d     = skid_f_q;
      skid_pc_d    = skid_pc_q;
      skid_imm_d   = skid_imm_q;

      if (flush) begin
         head_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (!head_valid_q || out_xfer) begin
         // Head is free this edge: refill from skid first to keep order.
         if (skid_valid_q) begin
            head_valid_d = 1'b1;
            head_f_d     = skid_f_q;
            head_pc_d    = skid_pc_q;
            head_imm_d   = skid_imm_q;
            skid_valid_d = 1'b0;
         end else if (in_xfer) begin
            head_valid_d = 1'b1;
            head_f_d     = dec;
            head_pc_d    = in_pc;
            head_imm_d   = dec_imm;
         end else begin
            head_valid_d = 1'b0;
         end
      end else if (in_xfer) begin
         // Head stalled: the accepted entry parks in the skid slot.
         skid_valid_d = 1'b1;
         skid_f_d     = dec;
         skid_pc_d    = in_pc;
         skid_imm_d   = dec_imm;
      end

      // An empty head presents fmt NONE and illegal 0.
      if (!head_valid_d) begin
         head_f_d.fmt     = FMT_NONE;
         head_f_d.illegal = 1'b0;
      end

      in_ready_d = !skid_valid_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_valid_q <= 1'b0;
         head_f_q     <= '0;
         head_pc_q    <= '0;
         head_imm_q   <= '0;
         skid_valid_q <= 1'b0;
         skid_f_q     <= '0;
         skid_pc_q    <= '0;
         skid_imm_q   <= '0;
         in_ready_q   <= 1'b0;
      end else begin
         head_valid_q <= head_valid_d;
         head_f_q     <= head_f_d;
         head_pc_q    <= head_pc_d;
         head_imm_q   <= head_imm_d;
         skid_valid_q <= skid_valid_d;
         skid_f_q     <= skid_f_d;
         skid_pc_q    <= skid_pc_d;
         skid_imm_q   <= skid_imm_d;
         in_ready_q   <= in_ready_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = head_valid_q;
   assign out_pc      = head_pc_q;
   assign out_opcode  = head_f_q.opcode;
   assign out_funct3  = head_f_q.funct3;
   assign out_funct7  = head_f_q.funct7;
   assign out_rs1     = head_f_q.rs1;
   assign out_rs2     = head_f_q.rs2;
   assign out_rd      = head_f_q.rd;
   assign out_imm     = head_imm_q;
   assign out_fmt     = head_f_q.fmt;
   assign out_illegal = head_f_q.illegal;

endmodule

// File: tb/tb_inst_decode_stage.sv
// Scoreboard bench for inst_decode_stage (XLEN=64 instance plus an XLEN=32
// instance fed identically).
module tb_inst_decode_stage;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [31:0] in_inst;
   logic [63:0] in_pc;
   logic        flush;
   logic        out_ready;

   logic        in_ready, out_valid, out_illegal;
   logic [63:0] out_pc, out_imm;
   logic [6:0]  out_opcode, out_funct7;
   logic [2:0]  out_funct3, out_fmt;
   logic [4:0]  out_rs1, out_rs2, out_rd;

   logic        in_ready32, out_valid32, out_illegal32;
   logic [31:0] out_pc32, out_imm32;
   logic [6:0]  out_opcode32, out_funct7_32;
   logic [2:0]  out_funct3_32, out_fmt32;
   logic [4:0]  out_rs1_32, out_rs2_32, out_rd32;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   typedef struct {
      logic [63:0] pc;
      logic [6:0]  opc;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [4:0]  rs1, rs2, rd;
      logic [63:0] imm;
      logic [2:0]  fmt;
      logic        illegal;
   } exp_t;

   exp_t q[$];
   logic armed;

   logic [6:0] opc_tab [14] = '{7'h33, 7'h3B, 7'h13, 7'h1B, 7'h03, 7'h67, 7'h73,
                                7'h0F, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F};

   inst_decode_stage #(.XLEN(64), .PC_W(64)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_inst(in_inst), .in_pc(in_pc), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
      .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
      .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal)
   );

   inst_decode_stage #(.XLEN(32), .PC_W(32)) dut32 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
      .in_inst(in_inst), .in_pc(in_pc[31:0]), .flush(flush),
      .out_valid(out_valid32), .out_ready(out_ready), .out_pc(out_pc32),
      .out_opcode(out_opcode32), .out_funct3(out_funct3_32), .out_funct7(out_funct7_32),
      .out_rs1(out_rs1_32), .out_rs2(out_rs2_32), .out_rd(out_rd32),
      .out_imm(out_imm32), .out_fmt(out_fmt32), .out_illegal(out_illegal32)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // in_ready comes up on the first edge after reset is released.
   always @(posedge clk or posedge rst) begin
      if (rst) armed <= 1'b0;
      else     armed <= 1'b1;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference decode straight from the format table and immediate bit layout,
   // immediates built as signed integer sums of weighted fields.
   function automatic exp_t model(input logic [31:0] w, input logic [63:0] pc);
      exp_t   e;
      longint v;
      longint s;
      e.pc  = pc;
      e.opc = w[6:0];
      e.rd  = w[11:7];
      e.f3  = w[14:12];
      e.rs1 = w[19:15];
      e.rs2 = w[24:20];
      e.f7  = w[31:25];
      s     = w[31] ? 1 : 0;
      if (w[1:0] != 2'b11) e.fmt = 3'd0;
      else begin
         case (w[6:0])
            7'h33, 7'h3B:                             e.fmt = 3'd1;
            7'h13, 7'h1B, 7'h03, 7'h67, 7'h73, 7'h0F: e.fmt = 3'd2;
            7'h23:                                    e.fmt = 3'd3;
            7'h63:                                    e.fmt = 3'd4;
            7'h37, 7'h17:                             e.fmt = 3'd5;
            7'h6F:                                    e.fmt = 3'd6;
            default:                                  e.fmt = 3'd0;
         endcase
      end
      e.illegal = (e.fmt == 3'd0);
      case (e.fmt)
         3'd2: v = longint'(w[31:20]) - s * 4096;
         3'd3: v = longint'(w[31:25]) * 32 + longint'(w[11:7]) - s * 4096;
         3'd4: v = longint'(w[7]) * 2048 + longint'(w[30:25]) * 32
                   + longint'(w[11:8]) * 2 - s * 4096;
         3'd5: v = longint'(w[31:12]) * 4096 - s * 64'h1_0000_0000;
         3'd6: v = longint'(w[19:12]) * 4096 + longint'(w[20]) * 2048
                   + longint'(w[30:21]) * 2 - s * 1048576;
         default: v = 0;
      endcase
      e.imm = v;
      return e;
   endfunction

   // Monitor / scoreboard, sampling on the falling edge.
   initial begin
      logic exp_ready, exp_valid;
      exp_t h;
      forever begin
         @(negedge clk);
         if (rst) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_pc", out_pc, 0);
            chk("rst_out_imm", out_imm, 0);
            chk("rst_out_fmt", out_fmt, 0);
            chk("rst_out_illegal", out_illegal, 0);
            chk("rst_out_valid32", out_valid32, 0);
            q.delete();
         end else begin
            exp_ready = armed && (q.size() < 2);
            exp_valid = (q.size() > 0);
            chk("in_ready", in_ready, exp_ready);
            chk("out_valid", out_valid, exp_valid);
            chk("in_ready32", in_ready32, exp_ready);
            chk("out_valid32", out_valid32, exp_valid);
            if (exp_valid) begin
               h = q[0];
               chk("out_pc", out_pc, h.pc);
               chk("out_opcode", out_opcode, h.opc);
               chk("out_funct3", out_funct3, h.f3);
               chk("out_funct7", out_funct7, h.f7);
               chk("out_rs1", out_rs1, h.rs1);
               chk("out_rs2", out_rs2, h.rs2);
               chk("out_rd", out_rd, h.rd);
               chk("out_imm", out_imm, h.imm);
               chk("out_fmt", out_fmt, h.fmt);
               chk("out_illegal", out_illegal, h.illegal);
               chk("out_pc32", out_pc32, h.pc[31:0]);
               chk("out_imm32", out_imm32, h.imm[31:0]);
               chk("out_fmt32", out_fmt32, h.fmt);
               if (out_ready) void'(q.pop_front());
            end else begin
               chk("idle_fmt", out_fmt, 0);
               chk("idle_illegal", out_illegal, 0);
            end
            if (in_valid && exp_ready && !flush) q.push_back(model(in_inst, in_pc));
            if (flush) q.delete();
         end
      end
   end

   // Hold one instruction on the input until it is accepted (bounded).
   task automatic send(input logic [31:0] w);
      bit done = 0;
      in_valid = 1'b1;
      in_inst  = w;
      in_pc    = {$urandom, $urandom};
      for (int n = 0; n < 50 && !done; n++) begin
         @(negedge clk);
         if (in_ready) done = 1;
         @(posedge clk);
         #1;
      end
      if (!done) begin
         miscompares++;
         $display("FAIL send_timeout: inst 0x%08h not accepted", w);
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      for (int n = 0; n < 30 && q.size() != 0; n++) @(posedge clk);
      #1;
      vectors++;
      if (q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d entries left, expected 0", q.size());
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_out_valid", out_valid, 0);
      chk("async_rst_in_ready", in_ready, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      rst = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0;
      flush = 1'b0; out_ready = 1'b0;
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Directed decode vectors, downstream always ready.
      out_ready = 1'b1;
      send(32'hFFF10093);
      send(32'hFE000EE3);
      send(32'h800002B7);
      send(32'h00000000);
      send(32'h0000007F);
      send(32'h00C58533);
      send(32'hFE112E23);
      send(32'hFFDFF06F);
      drain();

      // Three back-to-back with downstream stalled for four cycles.
      @(posedge clk); #1;
      fork
         begin
            out_ready = 1'b0;
            repeat (4) @(posedge clk);
            #1 out_ready = 1'b1;
         end
         begin
            send(32'h00100093);
            send(32'h00200113);
            send(32'h00300193);
         end
      join
      drain();

      // Flush with both entries full and a new instruction offered.
      out_ready = 1'b0;
      send(32'h00A00513);
      send(32'h00B00593);
      @(posedge clk); #1;
      in_valid = 1'b1; in_inst = 32'h00C00613; in_pc = 64'h1234;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      repeat (3) @(posedge clk); #1;
      out_ready = 1'b1;
      send(32'h00D00693);
      drain();

      // Reset pulsed in the middle of a stall.
      out_ready = 1'b0;
      send(32'h01000713);
      send(32'h01100793);
      do_reset();
      repeat (2) @(posedge clk); #1;
      out_ready = 1'b1;
      send(32'h01200813);
      drain();

      // Randomised traffic with random backpressure and occasional flush.
      for (int c = 0; c < 1500; c++) begin
         logic [31:0] w;
         @(posedge clk); #1;
         w = $urandom;
         if ($urandom_range(7) < 6) w[6:0] = opc_tab[$urandom_range(13)];
         in_valid  = ($urandom_range(3) != 0);
         in_inst   = w;
         in_pc     = {$urandom, $urandom};
         out_ready = ($urandom_range(2) != 0);
         flush     = ($urandom_range(39) == 0);
      end
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/inst_decode_stage.md
INST_DECODE_STAGE -- requirements
Module: inst_decode_stage

Interface
REQ-001 Parameter XLEN, default 64: width of the generated immediate; legal values are 32 and 64.
REQ-002 Parameter PC_W, default 64: width of the pass-through PC.
REQ-003 clk  in  1  the single clock; all state updates on the rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 in_valid  in  1  upstream holds a valid instruction.
REQ-006 in_ready  out  1  the stage accepts this cycle; a transfer occurs when in_valid && in_ready.
REQ-007 in_inst  in  32  raw instruction word.
REQ-008 in_pc  in  PC_W  PC of in_inst.
REQ-009 flush  in  1  discard all buffered entries.
REQ-010 out_valid  out  1  the decoded entry at the head is valid.
REQ-011 out_ready  in  1  downstream accepts; a transfer occurs when out_valid && out_ready.
REQ-012 out_pc  out  PC_W; out_opcode  out  7; out_funct3  out  3; out_funct7  out  7.
REQ-013 out_rs1  out  5; out_rs2  out  5; out_rd  out  5: register addresses.
REQ-014 out_imm  out  XLEN  sign-extended immediate.
REQ-015 out_fmt  out  3  format code: 0 NONE, 1 R, 2 I, 3 S, 4 B, 5 U, 6 J.
REQ-016 out_illegal  out  1  unsupported encoding.

Function
REQ-017 Field positions: opcode [6:0], rd [11:7], funct3 [14:12], rs1 [19:15], rs2 [24:20], funct7 [31:25].
REQ-018 Opcode-to-format mapping:
- R: 0110011, 0111011.
- I: 0010011, 0011011, 0000011, 1100111, 1110011, 0001111.
- S: 0100011.
- B: 1100011.
- U: 0110111, 0010111.
- J: 1101111.
- Any other opcode: fmt NONE, illegal=1.
REQ-019 The stage SHALL set illegal=1, fmt NONE and imm 0 whenever inst[1:0]!=2'b11; compressed instructions are unsupported.
REQ-020 Immediate by format, each sign-extended from inst[31] to XLEN:
- I: inst[31:20].
- S: {inst[31:25],inst[11:7]}.
- B: {inst[31],inst[7],inst[30:25],inst[11:8],0}.
- U: {inst[31:12],12'b0}.
- J: {inst[31],inst[19:12],inst[20],inst[30:21],0}.
- R and NONE: imm = 0.
REQ-021 Decoding is combinational on the input side; the result is registered on an input transfer, giving a latency of exactly 1 cycle from in transfer to out_valid.
REQ-022 Buffering is a 2-entry skid (head plus skid), with in_ready a registered signal equal to "skid entry empty".
REQ-023 While out_valid && !out_ready, all out_* SHALL remain stable.
REQ-024 Order SHALL be preserved with no loss or duplication.
REQ-025 On a simultaneous in transfer and out transfer, throughput is 1 per cycle.
REQ-026 When both entries are full, in_ready=0 in the next cycle; it returns to 1 in the cycle after the first out transfer.
REQ-027 With flush=1, both entries are invalidated at the next edge, out_valid=0 and in_ready=1 in the following cycle.
REQ-028 When flush coincides with an in transfer, the incoming instruction is dropped (flush wins).
REQ-029 When flush coincides with an out transfer, that out transfer still counts as completed.
REQ-030 Empty pipeline: out_valid=0; out_* data is don't-care except out_fmt=0 and out_illegal=0, which are held at their reset values.

Reset
REQ-031 While rst=1, asynchronously: out_valid=0, in_ready=0, both entries invalid, and all out_* data registers = 0.
REQ-032 in_ready=1 from the first clk edge after rst deasserts.
REQ-033 rst asserted mid-stall discards all buffered entries, with no partial output.

Structure
REQ-034 Shared package inst_pkg: opcode constants, the 3-bit format enum with the values of REQ-015, and field-position constants.
REQ-035 One combinational sub-module inst_imm_gen (inst, fmt -> XLEN imm) implements REQ-020; it is instantiated once, on the input side.

Verification
REQ-036 XLEN=64, inst 0xFFF10093 (addi x1,x2,-1) -> next cycle out_fmt=2, rd=1, rs1=2, imm=0xFFFFFFFFFFFFFFFF, illegal=0.
REQ-037 inst 0xFE000EE3 (beq x0,x0,-4) -> fmt=4, imm=0xFFFFFFFFFFFFFFFC; inst 0x800002B7 (lui x5,0x80000) -> fmt=5, rd=5, imm=0xFFFFFFFF80000000; XLEN=32 -> imm=0x80000000.
REQ-038 inst 0x00000000 and 0x0000007F -> illegal=1, fmt=0, imm=0.
REQ-039 Feed 3 back-to-back instructions with out_ready=0 for 4 cycles:
- in_ready falls after 2 accepted.
- out_* stays stable throughout.
- After out_ready=1, all 3 emerge in order at 1 per cycle.
REQ-040 flush with 2 entries full plus in_valid=1 -> next cycle out_valid=0, in_ready=1, and the dropped instruction never appears.
REQ-041 rst pulsed during a stall -> out_valid=0 immediately, without waiting for clk; in_ready=1 after the first edge post-deassert.
